gshare_branch_predictor: RTL

Parametrised gshare direction predictor, successor to the team's global-history predictor. Indexes a pattern history table (PHT) of N-bit saturating counters with PC bits XOR a speculatively updated global history register (GHR). Returns the GHR snapshot used for each prediction so the pipeline can carry it to resolution for training and for GHR recovery on mispredict. Sits in fetch; updates arrive from branch resolution in execute.

---
 rtl/gshare_branch_predictor.sv | 111 +++++++++++
 1 files changed

// File: rtl/gshare_branch_predictor.sv
// gshare direction predictor: PHT of saturating counters indexed by PC bits XOR a speculative GHR.
// Optional feature macro GSHARE_HASH_EN: when undefined the index is the GHR alone (pure global predictor).
module gshare_branch_predictor #(
    parameter int GHR_WIDTH = 8,
    parameter int CTR_WIDTH = 2,
    parameter int PC_WIDTH  = 32,
    parameter int IDX_LSB   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 predict_valid,
    input  logic [PC_WIDTH-1:0]  predict_pc,
    output logic                 resp_valid,
    output logic                 resp_taken,
    output logic [GHR_WIDTH-1:0] resp_ghr,
    input  logic                 update_valid,
    input  logic [PC_WIDTH-1:0]  update_pc,
    input  logic [GHR_WIDTH-1:0] update_ghr,
    input  logic                 update_taken,
    input  logic                 update_mispredict,
    output logic [15:0]          mispredict_count
);

    localparam int                   ENTRIES  = 1 << GHR_WIDTH;
    localparam logic [CTR_WIDTH-1:0] CTR_MAX  = '1;
    localparam logic [CTR_WIDTH-1:0] CTR_ONE  = CTR_WIDTH'(1);
    localparam logic [CTR_WIDTH-1:0] CTR_INIT = CTR_ONE << (CTR_WIDTH - 1);

    logic [CTR_WIDTH-1:0] pht_q [ENTRIES];
    logic [GHR_WIDTH-1:0] ghr_q, ghr_d;
    logic                 resp_valid_q;
    logic                 resp_taken_q;
    logic [GHR_WIDTH-1:0] resp_ghr_q;
    logic [15:0]          mispredict_count_q, mispredict_count_d;

    logic [GHR_WIDTH-1:0] pred_idx;
    logic [GHR_WIDTH-1:0] upd_idx;
    logic                 pred_taken;
    logic [CTR_WIDTH-1:0] upd_ctr_d;
    logic                 recover;

`ifdef GSHARE_HASH_EN
    assign pred_idx = predict_pc[IDX_LSB +: GHR_WIDTH] ^ ghr_q;
    assign upd_idx  = update_pc[IDX_LSB +: GHR_WIDTH] ^ update_ghr;
`else
    assign pred_idx = ghr_q;
    assign upd_idx  = update_ghr;
`endif

    // PC bits outside the hash slice (all of them in the pure global build) are intentionally unused.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{predict_pc, update_pc};

    // The read uses the pre-edge array, so a same-cycle write to the same entry is not seen.
    assign pred_taken = pht_q[pred_idx][CTR_WIDTH-1];
    assign recover    = update_valid && update_mispredict;

    always_comb begin
        upd_ctr_d = pht_q[upd_idx];
        if (update_taken) begin
            if (upd_ctr_d != CTR_MAX) upd_ctr_d = upd_ctr_d + CTR_ONE;
        end else begin
            if (upd_ctr_d != '0) upd_ctr_d = upd_ctr_d - CTR_ONE;
        end
    end

    // Recovery is applied last so it overrides the wrong-path speculative shift.
    always_comb begin
        ghr_d              = ghr_q;
        mispredict_count_d = mispredict_count_q;
        if (predict_valid) ghr_d = {ghr_q[GHR_WIDTH-2:0], pred_taken};
        if (recover) begin
            ghr_d = {update_ghr[GHR_WIDTH-2:0], update_taken};
            if (mispredict_count_q != 16'hFFFF) mispredict_count_d = mispredict_count_q + 16'd1;
        end
    end

    // NOTE: the PHT is built from flops with a real reset because every counter must
    // restart weakly taken; a RAM macro could not be cleared in a single edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) pht_q[i] <= CTR_INIT;
        end else if (update_valid) begin
            pht_q[upd_idx] <= upd_ctr_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghr_q              <= '0;
            resp_valid_q       <= 1'b0;
            resp_taken_q       <= 1'b0;
            resp_ghr_q         <= '0;
            mispredict_count_q <= '0;
        end else begin
            ghr_q              <= ghr_d;
            resp_valid_q       <= predict_valid;
            mispredict_count_q <= mispredict_count_d;
            if (predict_valid) begin
                resp_taken_q <= pred_taken;
                resp_ghr_q   <= ghr_q;
            end
        end
    end

    assign resp_valid       = resp_valid_q;
    assign resp_taken       = resp_taken_q;
    assign resp_ghr         = resp_ghr_q;
    assign mispredict_count = mispredict_count_q;

endmodule
